// File: rtl/updn_cnt_checker.sv
// Passive checker for an up/down counter: shadows the counter with a reference
// model and reports mismatches, a sticky flag, a saturating count and the first failing pair.
module updn_cnt_checker #(
   parameter int WIDTH       = 16,
   parameter int ERR_CNT_W   = 8,
   parameter bit HALT_ON_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_,
   input  logic                 chk_en,
   input  logic                 clr_err,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 ld_cnt,
   input  logic                 updn_cnt,
   input  logic                 count_enb,
   input  logic [WIDTH-1:0]     data_out,
   output logic                 chk_active,
   output logic                 mismatch,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [WIDTH-1:0]     first_exp,
   output logic [WIDTH-1:0]     first_act
);

   typedef enum logic [1:0] {IDLE, SYNC, CHECK, FAULT} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     model_q, model_d;
   logic                 chk_active_q, chk_active_d;
   logic                 mismatch_q, mismatch_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]     first_exp_q, first_exp_d;
   logic [WIDTH-1:0]     first_act_q, first_act_d;
   logic                 hit;

   // Counter next-state rule: load beats count, count beats hold, modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] cnt_next(input logic [WIDTH-1:0] cur);
      if (ld_cnt)
         return data_in;
      else if (count_enb)
         return updn_cnt ? cur + WIDTH'(1) : cur - WIDTH'(1);
      else
         return cur;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   // A clear on the same edge swallows the mismatch entirely.
   assign hit = (state_q == CHECK) && (data_out != model_q) && !clr_err;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= IDLE;
         model_q      <= '0;
         chk_active_q <= 1'b0;
         mismatch_q   <= 1'b0;
         sticky_q     <= 1'b0;
         err_cnt_q    <= '0;
         first_exp_q  <= '0;
         first_act_q  <= '0;
      end else begin
         state_q      <= state_d;
         model_q      <= model_d;
         chk_active_q <= chk_active_d;
         mismatch_q   <= mismatch_d;
         sticky_q     <= sticky_d;
         err_cnt_q    <= err_cnt_d;
         first_exp_q  <= first_exp_d;
         first_act_q  <= first_act_d;
      end
   end

   always_comb begin
      state_d = state_q;
      model_d = model_q;
      case (state_q)
         IDLE: begin
            if (chk_en) state_d = SYNC;
         end
         SYNC: begin
            if (!chk_en) begin
               state_d = IDLE;
            end else begin
               // Seed from the live counter so checking can start mid-run.
               model_d = cnt_next(data_out);
               state_d = CHECK;
            end
         end
         CHECK: begin
            model_d = cnt_next(model_q);
            if (!chk_en)                state_d = IDLE;
            else if (HALT_ON_ERR && hit) state_d = FAULT;
         end
         FAULT: begin
            if (clr_err) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      chk_active_d = (state_d == CHECK);
      mismatch_d   = hit;
      sticky_d     = sticky_q;
      err_cnt_d    = err_cnt_q;
      first_exp_d  = first_exp_q;
      first_act_d  = first_act_q;
      if (clr_err) begin
         sticky_d    = 1'b0;
         err_cnt_d   = '0;
         first_exp_d = '0;
         first_act_d = '0;
      end else if (hit) begin
         err_cnt_d = sat_inc(err_cnt_q);
         if (!sticky_q) begin
            sticky_d    = 1'b1;
            first_exp_d = model_q;
            first_act_d = data_out;
         end
      end
   end

   assign chk_active = chk_active_q;
   assign mismatch   = mismatch_q;
   assign err_sticky = sticky_q;
   assign err_count  = err_cnt_q;
   assign first_exp  = first_exp_q;
   assign first_act  = first_act_q;

endmodule

// File: tb/tb_updn_cnt_checker.sv
// Bench for updn_cnt_checker: three instances (default, 2-bit error count, halt-on-error)
// share stimulus and are compared against a behavioural model of the checking rules.
module tb_updn_cnt_checker;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_ = 1'b0, chk_en = 1'b0, clr_err = 1'b0, ld_cnt = 1'b0, updn_cnt = 1'b0, count_enb = 1'b0;
   logic [W-1:0] data_in = '0, data_out = '0;
   always #5 clk = ~clk;

   logic act[3], mm[3], st[3];
   logic [7:0] ec[3];
   logic [W-1:0] fe[3], fa[3];
   logic [7:0] ec0, ec2;
   logic [1:0] ec1;
   assign ec[0] = ec0;
   assign ec[1] = {6'b0, ec1};
   assign ec[2] = ec2;

   updn_cnt_checker #(.WIDTH(W), .ERR_CNT_W(8), .HALT_ON_ERR(1'b0)) u0 (
      .clk(clk), .rst_(rst_), .chk_en(chk_en), .clr_err(clr_err), .data_in(data_in),
      .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb), .data_out(data_out),
      .chk_active(act[0]), .mismatch(mm[0]), .err_sticky(st[0]), .err_count(ec0),
      .first_exp(fe[0]), .first_act(fa[0]));
   updn_cnt_checker #(.WIDTH(W), .ERR_CNT_W(2), .HALT_ON_ERR(1'b0)) u1 (
      .clk(clk), .rst_(rst_), .chk_en(chk_en), .clr_err(clr_err), .data_in(data_in),
      .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb), .data_out(data_out),
      .chk_active(act[1]), .mismatch(mm[1]), .err_sticky(st[1]), .err_count(ec1),
      .first_exp(fe[1]), .first_act(fa[1]));
   updn_cnt_checker #(.WIDTH(W), .ERR_CNT_W(8), .HALT_ON_ERR(1'b1)) u2 (
      .clk(clk), .rst_(rst_), .chk_en(chk_en), .clr_err(clr_err), .data_in(data_in),
      .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb), .data_out(data_out),
      .chk_active(act[2]), .mismatch(mm[2]), .err_sticky(st[2]), .err_count(ec2),
      .first_exp(fe[2]), .first_act(fa[2]));

   int nerr = 0, nchk = 0;

   // Reference model: phase 0 off, 1 seeding, 2 comparing, 3 halted.
   int  ph[3], m[3], e_cnt[3], e_fe[3], e_fa[3];
   bit  e_mm[3], e_st[3];
   int  cmax[3] = '{255, 3, 255};
   bit  halt[3] = '{1'b0, 1'b0, 1'b1};
   int  cnt = 0;

   function automatic int nxt(input int v);
      if (ld_cnt) return int'(data_in);
      if (count_enb) return updn_cnt ? (v + 1) % 65536 : (v + 65535) % 65536;
      return v;
   endfunction

   task automatic model_reset();
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         ph[k] = 0; m[k] = 0; e_cnt[k] = 0; e_fe[k] = 0; e_fa[k] = 0; e_mm[k] = 0; e_st[k] = 0;
      end
   endtask

   task automatic model_edge();
      int dout;
      dout = int'(data_out);
      for (int k = 0; k < 3; k++) begin
         bit hit;
         int old;
         hit = 0;
         old = m[k];
         case (ph[k])
            0: if (chk_en) ph[k] = 1;
            1: if (!chk_en) ph[k] = 0; else begin m[k] = nxt(dout); ph[k] = 2; end
            2: begin
               hit = (dout != m[k]) && !clr_err;
               m[k] = nxt(m[k]);
               if (!chk_en) ph[k] = 0;
               else if (hit && halt[k]) ph[k] = 3;
            end
            default: if (clr_err) ph[k] = 0;
         endcase
         if (clr_err) begin
            e_mm[k] = 0; e_cnt[k] = 0; e_st[k] = 0; e_fe[k] = 0; e_fa[k] = 0;
         end else begin
            e_mm[k] = hit;
            if (hit) begin
               if (e_cnt[k] < cmax[k]) e_cnt[k]++;
               if (!e_st[k]) begin e_st[k] = 1; e_fe[k] = old; e_fa[k] = dout; end
            end
         end
      end
   endtask

   task automatic drive(input bit en, input bit clr, input bit ld, input bit up, input bit enb,
                        input int din, input int off);
      chk_en = en; clr_err = clr; ld_cnt = ld; updn_cnt = up; count_enb = enb;
      data_in = 16'(din);
      data_out = 16'(cnt + off);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_) begin
         model_edge();
         cnt = nxt(cnt);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      model_reset();
      drive(1, 0, 0, 1, 1, 0, 0);
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         nchk++;
         if ({act[k], mm[k], st[k], ec[k], fe[k], fa[k]} !== '0) begin
            nerr++;
            $display("FAIL reset u%0d: act/mm/st/cnt/fe/fa=%b/%b/%b/%0d/%h/%h want all 0",
                     k, act[k], mm[k], st[k], ec[k], fe[k], fa[k]);
         end
      end
      rst_ = 1'b1;
      drive(1, 0, 0, 1, 1, 0, 0);
   endtask

   task automatic test_count_up();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, 1, 1, 0, 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            nchk++;
            if ({act[k], mm[k], st[k], ec[k]} !== {ph[k] == 2, e_mm[k], e_st[k], 8'(e_cnt[k])}) begin
               nerr++;
               $display("FAIL count_up u%0d cyc%0d: act/mm/st/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                        k, i, act[k], mm[k], st[k], ec[k], ph[k] == 2, e_mm[k], e_st[k], e_cnt[k]);
            end
         end
      end
      nchk++;
      if (act[0] !== 1'b1 || ec[0] !== 8'd0) begin
         nerr++;
         $display("FAIL count_up_end: act=%b cnt=%0d want act=1 cnt=0", act[0], ec[0]);
      end
   endtask

   task automatic test_wrap();
      int ld_v[6]  = '{1, 0, 0, 0, 1, 0};
      int up_v[6]  = '{1, 1, 1, 1, 1, 0};
      int din_v[6] = '{16'hFFFE, 0, 0, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, ld_v[i][0], up_v[i][0], 1, din_v[i], 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            nchk++;
            if (mm[k] !== 1'b0 || ec[k] !== 8'(e_cnt[k]) || act[k] !== 1'b1) begin
               nerr++;
               $display("FAIL wrap u%0d step%0d: mm=%b cnt=%0d act=%b want mm=0 cnt=%0d act=1",
                        k, i, mm[k], ec[k], act[k], e_cnt[k]);
            end
         end
      end
   endtask

   task automatic test_single_error();
      int pe, pa;
      pe = cnt;
      pa = (cnt + 1) % 65536;
      drive(1, 0, 0, 1, 1, 0, 1);
      tick();
      nchk++;
      if (mm[0] !== 1'b1 || ec[0] !== 8'd1 || st[0] !== 1'b1 || fe[0] !== 16'(pe) || fa[0] !== 16'(pa)) begin
         nerr++;
         $display("FAIL single_err: mm=%b cnt=%0d st=%b fe=%h fa=%h want 1/1/1/%h/%h",
                  mm[0], ec[0], st[0], fe[0], fa[0], 16'(pe), 16'(pa));
      end
      drive(1, 0, 0, 1, 1, 0, 0);
      tick();
      nchk++;
      if (mm[0] !== 1'b0 || ec[0] !== 8'd1 || act[2] !== 1'b0 || ec[2] !== 8'd1) begin
         nerr++;
         $display("FAIL single_err_after: mm0=%b cnt0=%0d act2=%b cnt2=%0d want 0/1/0/1",
                  mm[0], ec[0], act[2], ec[2]);
      end
      for (int k = 0; k < 3; k++) begin
         nchk++;
         if ({act[k], mm[k], st[k], ec[k], fe[k], fa[k]} !==
             {ph[k] == 2, e_mm[k], e_st[k], 8'(e_cnt[k]), 16'(e_fe[k]), 16'(e_fa[k])}) begin
            nerr++;
            $display("FAIL single_err_model u%0d: act/mm/st/cnt/fe/fa=%b/%b/%b/%0d/%h/%h want %b/%b/%b/%0d/%h/%h",
                     k, act[k], mm[k], st[k], ec[k], fe[k], fa[k],
                     ph[k] == 2, e_mm[k], e_st[k], e_cnt[k], 16'(e_fe[k]), 16'(e_fa[k]));
         end
      end
   endtask

   task automatic test_clear();
      drive(1, 1, 0, 1, 1, 0, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         nchk++;
         if ({mm[k], st[k], ec[k], fe[k], fa[k]} !== '0) begin
            nerr++;
            $display("FAIL clear u%0d: mm/st/cnt/fe/fa=%b/%b/%0d/%h/%h want all 0",
                     k, mm[k], st[k], ec[k], fe[k], fa[k]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 1, 1, 0, 0);
         tick();
         nchk++;
         if (act[2] !== (i >= 1) || mm[2] !== 1'b0 || st[2] !== 1'b0) begin
            nerr++;
            $display("FAIL clear_resync cyc%0d: act2=%b mm2=%b st2=%b want %b/0/0",
                     i, act[2], mm[2], st[2], i >= 1);
         end
      end
   endtask

   task automatic test_persistent();
      int pe, pa;
      pe = cnt;
      pa = (cnt + 1) % 65536;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, 1, 1, 0, 1);
         tick();
      end
      nchk++;
      if (ec[0] !== 8'd6 || ec[1] !== 8'd3 || ec[2] !== 8'd1 || mm[0] !== 1'b1 || act[2] !== 1'b0) begin
         nerr++;
         $display("FAIL persist_cnt: cnt0/1/2=%0d/%0d/%0d mm0=%b act2=%b want 6/3/1 1 0",
                  ec[0], ec[1], ec[2], mm[0], act[2]);
      end
      for (int k = 0; k < 2; k++) begin
         nchk++;
         if (fe[k] !== 16'(pe) || fa[k] !== 16'(pa) || st[k] !== 1'b1) begin
            nerr++;
            $display("FAIL persist_first u%0d: fe=%h fa=%h st=%b want %h/%h/1",
                     k, fe[k], fa[k], st[k], 16'(pe), 16'(pa));
         end
      end
      drive(1, 1, 0, 1, 1, 0, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 1, 1, 0, 0);
         tick();
      end
   endtask

   task automatic test_clr_collision();
      drive(1, 1, 0, 1, 1, 0, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         nchk++;
         if (mm[k] !== 1'b0 || ec[k] !== 8'd0 || st[k] !== 1'b0 || act[k] !== 1'b1) begin
            nerr++;
            $display("FAIL clr_collision u%0d: mm=%b cnt=%0d st=%b act=%b want 0/0/0/1",
                     k, mm[k], ec[k], st[k], act[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 20) != 0, ($urandom % 25) == 0, ($urandom % 8) == 0,
               1'($urandom), ($urandom % 4) != 0, int'($urandom % 65536),
               (($urandom % 10) == 0) ? int'($urandom_range(1, 3)) : 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            nchk++;
            if ({act[k], mm[k], st[k], ec[k], fe[k], fa[k]} !==
                {ph[k] == 2, e_mm[k], e_st[k], 8'(e_cnt[k]), 16'(e_fe[k]), 16'(e_fa[k])}) begin
               nerr++;
               $display("FAIL random u%0d cyc%0d: act/mm/st/cnt/fe/fa=%b/%b/%b/%0d/%h/%h want %b/%b/%b/%0d/%h/%h",
                        k, i, act[k], mm[k], st[k], ec[k], fe[k], fa[k],
                        ph[k] == 2, e_mm[k], e_st[k], e_cnt[k], 16'(e_fe[k]), 16'(e_fa[k]));
            end
         end
      end
   endtask

   task automatic test_reset_midcheck();
      drive(0, 1, 0, 1, 1, 0, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 1, 1, 0, 0);
         tick();
      end
      drive(1, 0, 0, 1, 1, 0, 2);
      tick();
      nchk++;
      if (st[0] !== 1'b1 || act[0] !== 1'b1 || mm[0] !== 1'b1) begin
         nerr++;
         $display("FAIL midcheck_pre: st0=%b act0=%b mm0=%b want 1/1/1", st[0], act[0], mm[0]);
      end
      #2 rst_ = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         nchk++;
         if ({act[k], mm[k], st[k], ec[k], fe[k], fa[k]} !== '0) begin
            nerr++;
            $display("FAIL midcheck_reset u%0d: act/mm/st/cnt/fe/fa=%b/%b/%b/%0d/%h/%h want all 0",
                     k, act[k], mm[k], st[k], ec[k], fe[k], fa[k]);
         end
      end
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_count_up();
      test_wrap();
      test_single_error();
      test_clear();
      test_persistent();
      test_clr_collision();
      test_random();
      test_reset_midcheck();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/updn_cnt_checker.md
Name: updn_cnt_checker

Overview:
- Passive, synthesizable checker that watches the up/down counter's control inputs and its data_out, runs a cycle-accurate reference model, and flags mismatches.
- Sits beside the counter in the bench or in silicon debug.
- Reports a mismatch pulse, a sticky error flag, a saturating error count, and the first failing expected/actual pair.

Parameters:
- WIDTH, 16, counter data width.
- ERR_CNT_W, 8, width of the saturating error counter.
- HALT_ON_ERR, 0; 1 = stop checking after the first mismatch (enter FAULT).

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst_  input  1  asynchronous active-low reset; same net that resets the counter.
- chk_en  input  1  enable checking; low = IDLE.
- clr_err  input  1  synchronous clear of all error state.
- data_in  input  WIDTH  counter load value, observed.
- ld_cnt  input  1  counter load strobe, observed.
- updn_cnt  input  1  counter direction (1 = up, 0 = down), observed.
- count_enb  input  1  counter count enable, observed.
- data_out  input  WIDTH  counter output, observed.
- chk_active  output  1  high in the CHECK state.
- mismatch  output  1  one-cycle pulse on each detected mismatch.
- err_sticky  output  1  set on the first mismatch; held until clr_err or reset.
- err_count  output  ERR_CNT_W  mismatch count, saturates at all-ones.
- first_exp  output  WIDTH  model value at the first mismatch.
- first_act  output  WIDTH  data_out value at the first mismatch.

Behaviour:
- Reset (rst_ low, async):
  - state = IDLE; model = 0.
  - All outputs 0.
  - No checking while rst_ is low.
- Model next-state, applied at each posedge (priority order):
  - ld_cnt = 1: load data_in.
  - else count_enb = 1: count up if updn_cnt = 1, down if 0. Arithmetic is modulo 2^WIDTH, so all-ones+1 wraps to 0 and 0-1 wraps to all-ones.
  - else hold.
- Compare rule, evaluated at each posedge in CHECK, before the model updates:
  - mismatch_raw = (data_out != model).
  - model then takes its next state from the same-edge inputs.
  - Both values therefore represent the counter state after the previous edge.
- FSM states:
  - IDLE: model tracks nothing. When chk_en = 1, go to SYNC.
  - SYNC (1 cycle): model <= next-state function applied to the sampled data_out and current inputs, which seeds the model mid-run without a false error. Then go to CHECK. If chk_en drops, go to IDLE.
  - CHECK: compare and update every cycle. chk_en = 0 goes to IDLE. A mismatch with HALT_ON_ERR = 1 goes to FAULT.
  - FAULT: no compares. Stays until clr_err = 1 (go to IDLE) or reset.
- First compare after reset release: rst_ rises with chk_en already high, giving IDLE → SYNC → CHECK. The first compare happens on the 3rd posedge after release.
- On a mismatch in CHECK:
  - mismatch = 1 for one cycle, registered; visible the cycle after the failing edge.
  - err_count increments unless it is already all-ones.
  - If err_sticky was 0: capture first_exp/first_act and set err_sticky.
  - Later mismatches never overwrite the capture.
- After a mismatch with HALT_ON_ERR = 0, the model keeps its own trajectory and does not resync to data_out. A persistent offset therefore yields a mismatch every cycle.
- clr_err = 1:
  - Next posedge: err_sticky, err_count, first_exp and first_act go to 0; mismatch is forced to 0.
  - The state is unchanged except FAULT → IDLE.
  - clr_err on the same edge as a new mismatch: clear wins and the mismatch is dropped.
- Reset mid-check: everything clears asynchronously, including the capture registers.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then chk_en = 1, ld_cnt = 0, count_enb = 1, updn_cnt = 1 for 20 cycles with a correct counter → data_out runs 0..N, chk_active = 1 from the 3rd edge, mismatch never asserts, err_count = 0.
- Load 16'hFFFE, count up 3 → model reaches 16'hFFFF, 0, 1; no mismatch. Load 0, count down 1 → 16'hFFFF; no mismatch.
- Force data_out = model+1 for one cycle → mismatch pulses once, err_count = 1, first_exp/first_act hold the correct pair, err_sticky = 1.
- ERR_CNT_W = 2, persistent error for 6 cycles, HALT_ON_ERR = 0 → err_count saturates at 3; first_* unchanged after the first error.
- HALT_ON_ERR = 1, inject one error → FAULT, chk_active = 0, no further counts. clr_err → IDLE with all error outputs at 0; chk_en high gives SYNC then CHECK with no false error.
- Assert rst_ low mid-CHECK with err_sticky = 1 → all outputs 0 immediately, without waiting for a clock edge.
